// File: rtl/mips_bus_pkg.sv
// Shared types for the two-master MIPS bus arbiter: FSM states, owner tags and the
// registered bus command (fields sized for buses up to 32 bits wide).
package mips_bus_pkg;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;
    localparam int BUS_BE_W   = BUS_DATA_W / 8;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RDWAIT,
        DONE
    } arb_state_t;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } owner_t;

    typedef struct packed {
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wdata;
        logic [BUS_BE_W-1:0]   be;
        logic                  is_write;
    } bus_cmd_t;

endpackage

// File: rtl/mips_rr_pick.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the master
// that was not granted last time.
module mips_rr_pick
    import mips_bus_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_owner,
    output owner_t     grant
);

    always_comb begin
        grant = M0;
        if (req == 2'b10) begin
            grant = M1;
        end else if (req == 2'b11) begin
            grant = (last_owner == M0) ? M1 : M0;
        end
    end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Shares one Avalon-style slave bus between the fetch (m0) and load/store (m1) ports,
// one transaction at a time. Define MIPS_ARB_FIXED_PRIO_EN to give ties to m1 always.
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,

    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata
);

    localparam int         BE_W     = DATA_W / 8;
    localparam logic [2:0] LAT_INIT = 3'(READ_LATENCY - 1);

    arb_state_t state;
    bus_cmd_t   cmd;
    bus_cmd_t   sel_cmd;
    owner_t     owner;
    owner_t     grant;
    logic [2:0] rd_count;
    logic [1:0] req;

    assign req = {m1_read | m1_write, m0_read | m0_write};

`ifdef MIPS_ARB_FIXED_PRIO_EN
    assign grant = req[1] ? M1 : M0;
`else
    owner_t rr_last;

    mips_rr_pick u_pick (
        .req        (req),
        .last_owner (rr_last),
        .grant      (grant)
    );

    // Starts at M1 so that the first tie after reset goes to the fetch port.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last <= M1;
        end else if (state == IDLE && req != 2'b00) begin
            rr_last <= grant;
        end
    end
`endif

    // A master raising read and write together is treated as a write.
    always_comb begin
        sel_cmd = '0;
        if (grant == M1) begin
            sel_cmd.addr     = BUS_ADDR_W'(m1_address);
            sel_cmd.wdata    = BUS_DATA_W'(m1_writedata);
            sel_cmd.be       = BUS_BE_W'(m1_byteenable);
            sel_cmd.is_write = m1_write;
        end else begin
            sel_cmd.addr     = BUS_ADDR_W'(m0_address);
            sel_cmd.wdata    = BUS_DATA_W'(m0_writedata);
            sel_cmd.be       = BUS_BE_W'(m0_byteenable);
            sel_cmd.is_write = m0_write;
        end
    end

    assign s_address    = ADDR_W'(cmd.addr);
    assign s_writedata  = DATA_W'(cmd.wdata);
    assign s_byteenable = BE_W'(cmd.be);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cmd            <= '0;
            owner          <= M0;
            rd_count       <= '0;
            s_read         <= 1'b0;
            s_write        <= 1'b0;
            m0_waitrequest <= 1'b1;
            m1_waitrequest <= 1'b1;
            m0_readdata    <= '0;
            m1_readdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        cmd     <= sel_cmd;
                        owner   <= grant;
                        s_read  <= !sel_cmd.is_write;
                        s_write <= sel_cmd.is_write;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!s_waitrequest) begin
                        s_read  <= 1'b0;
                        s_write <= 1'b0;
                        if (cmd.is_write) begin
                            if (owner == M0) m0_waitrequest <= 1'b0;
                            else             m1_waitrequest <= 1'b0;
                            state <= DONE;
                        end else begin
                            rd_count <= LAT_INIT;
                            state    <= RDWAIT;
                        end
                    end
                end
                RDWAIT: begin
                    // Read data arrives READ_LATENCY cycles after the strobe was accepted.
                    if (rd_count == '0) begin
                        if (owner == M0) begin
                            m0_readdata    <= s_readdata;
                            m0_waitrequest <= 1'b0;
                        end else begin
                            m1_readdata    <= s_readdata;
                            m1_waitrequest <= 1'b0;
                        end
                        state <= DONE;
                    end else begin
                        rd_count <= rd_count - 3'd1;
                    end
                end
                DONE: begin
                    m0_waitrequest <= 1'b1;
                    m1_waitrequest <= 1'b1;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Self-checking bench for mips_bus_arbiter: one instance with READ_LATENCY=1 and a
// second with READ_LATENCY=3, each with a small slave model feeding readdata.
module tb_mips_bus_arbiter;
    import mips_bus_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic [31:0] m0_address = '0, m1_address = '0;
    logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [31:0] m0_writedata = '0, m1_writedata = '0;
    logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic [31:0] s_address, s_writedata, s_readdata;
    logic        s_read, s_write, s_waitrequest;
    logic [3:0]  s_byteenable;

    logic [31:0] r3_m1_address = '0;
    logic        r3_m1_read = 1'b0;
    logic [31:0] r3_zero32;
    logic [3:0]  r3_zero4;
    logic        r3_zero1;
    logic        r3_m0_waitrequest, r3_m1_waitrequest;
    logic [31:0] r3_m0_readdata, r3_m1_readdata;
    logic [31:0] r3_s_address, r3_s_writedata, r3_s_readdata;
    logic        r3_s_read, r3_s_write;
    logic [3:0]  r3_s_byteenable;

    int          total = 0;
    int          bad = 0;
    int          stall_req = 0;
    int          stall_done = 0;
    logic [31:0] rdata1 = '0, rdata3 = '0;
    logic        rd_v1 = 1'b0;
    logic [2:0]  rd_v3 = '0;

    typedef struct {
        logic        owner;
        logic        is_read;
        logic [31:0] data;
        int          lat;
    } exp_t;
    exp_t exp_q[$];

    assign r3_zero32 = '0;
    assign r3_zero4  = '0;
    assign r3_zero1  = 1'b0;

    always #5 clk = ~clk;

    mips_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(1)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata)
    );

    mips_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(3)) dut_rl3 (
        .clk(clk), .reset(reset),
        .m0_address(r3_zero32), .m0_read(r3_zero1), .m0_write(r3_zero1),
        .m0_writedata(r3_zero32), .m0_byteenable(r3_zero4),
        .m0_waitrequest(r3_m0_waitrequest), .m0_readdata(r3_m0_readdata),
        .m1_address(r3_m1_address), .m1_read(r3_m1_read), .m1_write(r3_zero1),
        .m1_writedata(r3_zero32), .m1_byteenable(r3_zero4),
        .m1_waitrequest(r3_m1_waitrequest), .m1_readdata(r3_m1_readdata),
        .s_address(r3_s_address), .s_read(r3_s_read), .s_write(r3_s_write),
        .s_writedata(r3_s_writedata), .s_byteenable(r3_s_byteenable),
        .s_waitrequest(r3_zero1), .s_readdata(r3_s_readdata)
    );

    // Slave models: stall for stall_req cycles per strobe, readdata valid only in its latency slot.
    assign s_waitrequest = (s_read | s_write) && (stall_done < stall_req);
    assign s_readdata    = rd_v1 ? rdata1 : 32'hDEADBEEF;
    assign r3_s_readdata = rd_v3[2] ? rdata3 : 32'hDEADBEEF;

    always @(posedge clk) begin
        if (s_read | s_write) begin
            if (s_waitrequest) stall_done <= stall_done + 1;
        end else begin
            stall_done <= 0;
        end
        rd_v1 <= s_read && !s_waitrequest;
        rd_v3 <= {rd_v3[1:0], r3_s_read};
    end

    task automatic clear_masters();
        m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
        m0_address = '0; m1_address = '0; m0_writedata = '0; m1_writedata = '0;
        m0_byteenable = '0; m1_byteenable = '0;
    endtask

    // Waits for a completion pulse on the RL=1 instance; cyc=1 is the cycle the request is seen.
    task automatic wait_done(output int cyc, output logic who, output logic ok,
                             output int rd_hi, output int wr_hi, output logic [31:0] wd,
                             output logic [3:0] be, output logic [31:0] addr);
        cyc = 1; who = 1'b0; ok = 1'b0; rd_hi = 0; wr_hi = 0; wd = '0; be = '0; addr = '0;
        while (!ok && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (s_read) rd_hi++;
            if (s_write) begin
                wr_hi++;
                wd = s_writedata;
                be = s_byteenable;
            end
            if (s_read | s_write) addr = s_address;
            if (!m0_waitrequest || !m1_waitrequest) begin
                ok  = 1'b1;
                who = m0_waitrequest;
            end
        end
        if (ok) begin
            if (who) begin m1_read = 1'b0; m1_write = 1'b0; end
            else     begin m0_read = 1'b0; m0_write = 1'b0; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_masters();
        repeat (2) @(negedge clk);
        total++; if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin bad++; $display("[TB] FAIL reset_wait: got %b want 11", {m0_waitrequest, m1_waitrequest}); end
        total++; if ({s_read, s_write} !== 2'b00) begin bad++; $display("[TB] FAIL reset_strobe: got %b want 00", {s_read, s_write}); end
        total++; if ({s_address, s_writedata, s_byteenable} !== 68'h0) begin bad++; $display("[TB] FAIL reset_sbus: got %h %h %h want 0", s_address, s_writedata, s_byteenable); end
        total++; if ({m0_readdata, m1_readdata} !== 64'h0) begin bad++; $display("[TB] FAIL reset_rdata: got %h %h want 0", m0_readdata, m1_readdata); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_tie();
        int cyc, rd_hi, wr_hi; logic who, ok; logic [31:0] wd, addr; logic [3:0] be; exp_t e;
`ifdef MIPS_ARB_FIXED_PRIO_EN
        exp_q.push_back('{1'b1, 1'b0, 32'h22222222, 3});
        exp_q.push_back('{1'b1, 1'b0, 32'h44444444, 4});
        exp_q.push_back('{1'b0, 1'b0, 32'h11111111, 4});
`else
        exp_q.push_back('{1'b0, 1'b0, 32'h11111111, 3});
        exp_q.push_back('{1'b1, 1'b0, 32'h22222222, 4});
        exp_q.push_back('{1'b0, 1'b0, 32'h33333333, 4});
`endif
        m0_address = RESET_VECTOR + 32'h100; m0_writedata = 32'h11111111; m0_byteenable = 4'hF; m0_write = 1'b1;
        m1_address = RESET_VECTOR + 32'h200; m1_writedata = 32'h22222222; m1_byteenable = 4'hF; m1_write = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_done(cyc, who, ok, rd_hi, wr_hi, wd, be, addr);
            e = exp_q.pop_front();
            total++; if (!ok || who !== e.owner) begin bad++; $display("[TB] FAIL tie_owner[%0d]: got %b (done=%b) want %b", k, who, ok, e.owner); end
            total++; if (cyc !== e.lat) begin bad++; $display("[TB] FAIL tie_latency[%0d]: got %0d want %0d", k, cyc, e.lat); end
            total++; if (wd !== e.data) begin bad++; $display("[TB] FAIL tie_wdata[%0d]: got %h want %h", k, wd, e.data); end
            total++; if ((who ? m0_waitrequest : m1_waitrequest) !== 1'b1) begin bad++; $display("[TB] FAIL tie_nonowner_wait[%0d]: got 0 want 1", k); end
            // The first winner immediately requests again, forcing a second tie.
            if (k == 0) begin
                if (who) begin m1_writedata = 32'h44444444; m1_write = 1'b1; end
                else     begin m0_writedata = 32'h33333333; m0_write = 1'b1; end
            end
        end
        clear_masters();
        @(negedge clk);
    endtask

    task automatic test_m0_read();
        int cyc, rd_hi, wr_hi; logic who, ok; logic [31:0] wd, addr; logic [3:0] be; exp_t e;
        rdata1 = 32'h3C08BFC0;
        exp_q.push_back('{1'b0, 1'b1, 32'h3C08BFC0, 4});
        m0_address = RESET_VECTOR; m0_byteenable = 4'hF; m0_read = 1'b1;
        wait_done(cyc, who, ok, rd_hi, wr_hi, wd, be, addr);
        e = exp_q.pop_front();
        total++; if (!ok || who !== e.owner) begin bad++; $display("[TB] FAIL m0rd_owner: got %b (done=%b) want %b", who, ok, e.owner); end
        total++; if (cyc !== e.lat) begin bad++; $display("[TB] FAIL m0rd_latency: got %0d want %0d", cyc, e.lat); end
        total++; if (m0_readdata !== e.data) begin bad++; $display("[TB] FAIL m0rd_data: got %h want %h", m0_readdata, e.data); end
        total++; if (rd_hi !== 1 || wr_hi !== 0) begin bad++; $display("[TB] FAIL m0rd_strobes: got rd=%0d wr=%0d want rd=1 wr=0", rd_hi, wr_hi); end
        total++; if (addr !== RESET_VECTOR) begin bad++; $display("[TB] FAIL m0rd_addr: got %h want %h", addr, RESET_VECTOR); end
        total++; if (m1_waitrequest !== 1'b1 || m1_readdata !== 32'h0) begin bad++; $display("[TB] FAIL m0rd_m1_side: got wait=%b data=%h want 1 0", m1_waitrequest, m1_readdata); end
        @(negedge clk);
        total++; if (m0_waitrequest !== 1'b1) begin bad++; $display("[TB] FAIL m0rd_pulse_width: got %b want 1", m0_waitrequest); end
        clear_masters();
    endtask

    task automatic test_m1_write_stall();
        int cyc, rd_hi, wr_hi; logic who, ok; logic [31:0] wd, addr; logic [3:0] be; exp_t e;
        stall_req = 2;
        exp_q.push_back('{1'b1, 1'b0, 32'h0000006F, 5});
        m1_address = 32'hBFC00018; m1_writedata = 32'h0000006F; m1_byteenable = 4'b1111; m1_write = 1'b1;
        wait_done(cyc, who, ok, rd_hi, wr_hi, wd, be, addr);
        e = exp_q.pop_front();
        total++; if (!ok || who !== e.owner) begin bad++; $display("[TB] FAIL stall_owner: got %b (done=%b) want %b", who, ok, e.owner); end
        total++; if (cyc !== e.lat) begin bad++; $display("[TB] FAIL stall_latency: got %0d want %0d", cyc, e.lat); end
        total++; if (wr_hi !== 3) begin bad++; $display("[TB] FAIL stall_write_cycles: got %0d want 3", wr_hi); end
        total++; if (wd !== e.data || be !== 4'b1111 || addr !== 32'hBFC00018) begin bad++; $display("[TB] FAIL stall_bus: got %h %b %h want %h 1111 bfc00018", wd, be, addr, e.data); end
        total++; if (m0_readdata !== 32'h3C08BFC0) begin bad++; $display("[TB] FAIL stall_m0_rdata_kept: got %h want 3c08bfc0", m0_readdata); end
        stall_req = 0;
        clear_masters();
        @(negedge clk);
    endtask

    task automatic test_rw_both();
        int cyc, rd_hi, wr_hi; logic who, ok; logic [31:0] wd, addr; logic [3:0] be; exp_t e;
        exp_q.push_back('{1'b0, 1'b0, 32'h12345678, 3});
        m0_address = 32'h80001000; m0_writedata = 32'h12345678; m0_byteenable = 4'b0011;
        m0_read = 1'b1; m0_write = 1'b1;
        wait_done(cyc, who, ok, rd_hi, wr_hi, wd, be, addr);
        e = exp_q.pop_front();
        total++; if (!ok || who !== e.owner || cyc !== e.lat) begin bad++; $display("[TB] FAIL rw_done: got owner=%b cyc=%0d want %b %0d", who, cyc, e.owner, e.lat); end
        total++; if (rd_hi !== 0 || wr_hi !== 1) begin bad++; $display("[TB] FAIL rw_strobes: got rd=%0d wr=%0d want rd=0 wr=1", rd_hi, wr_hi); end
        total++; if (wd !== e.data || be !== 4'b0011) begin bad++; $display("[TB] FAIL rw_bus: got %h %b want %h 0011", wd, be, e.data); end
        total++; if (m0_readdata !== 32'h3C08BFC0) begin bad++; $display("[TB] FAIL rw_rdata_kept: got %h want 3c08bfc0", m0_readdata); end
        clear_masters();
        @(negedge clk);
    endtask

    task automatic test_read_latency3();
        int cyc; exp_t e;
        rdata3 = 32'h0000000B;
        exp_q.push_back('{1'b1, 1'b1, 32'h0000000B, 6});
        r3_m1_address = 32'h80000040; r3_m1_read = 1'b1;
        cyc = 1;
        while (r3_m1_waitrequest && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        r3_m1_read = 1'b0;
        e = exp_q.pop_front();
        total++; if (r3_m1_waitrequest !== 1'b0 || cyc !== e.lat) begin bad++; $display("[TB] FAIL rl3_latency: got cyc=%0d want %0d", cyc, e.lat); end
        total++; if (r3_m1_readdata !== e.data) begin bad++; $display("[TB] FAIL rl3_data: got %h want %h", r3_m1_readdata, e.data); end
        total++; if (r3_m0_waitrequest !== 1'b1) begin bad++; $display("[TB] FAIL rl3_m0_wait: got %b want 1", r3_m0_waitrequest); end
        @(negedge clk);
        total++; if (r3_m1_waitrequest !== 1'b1) begin bad++; $display("[TB] FAIL rl3_pulse_width: got %b want 1", r3_m1_waitrequest); end
    endtask

    task automatic test_reset_rdwait();
        int cyc, rd_hi, wr_hi; logic who, ok; logic [31:0] wd, addr; logic [3:0] be; exp_t e;
        rdata1 = 32'hCAFEF00D;
        m1_address = 32'h80002000; m1_byteenable = 4'hF; m1_read = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++; if ({s_read, s_write, m0_waitrequest, m1_waitrequest} !== 4'b0011) begin bad++; $display("[TB] FAIL rdwait_reset_ctl: got %b want 0011", {s_read, s_write, m0_waitrequest, m1_waitrequest}); end
        total++; if ({m0_readdata, m1_readdata} !== 64'h0) begin bad++; $display("[TB] FAIL rdwait_reset_rdata: got %h %h want 0", m0_readdata, m1_readdata); end
        total++; if (s_address !== 32'h0) begin bad++; $display("[TB] FAIL rdwait_reset_addr: got %h want 0", s_address); end
        reset = 1'b0;
        rdata1 = 32'h0000BEEF;
        exp_q.push_back('{1'b1, 1'b1, 32'h0000BEEF, 4});
        wait_done(cyc, who, ok, rd_hi, wr_hi, wd, be, addr);
        e = exp_q.pop_front();
        total++; if (!ok || who !== e.owner || cyc !== e.lat) begin bad++; $display("[TB] FAIL rdwait_reserve: got owner=%b cyc=%0d want %b %0d", who, cyc, e.owner, e.lat); end
        total++; if (m1_readdata !== e.data || addr !== 32'h80002000) begin bad++; $display("[TB] FAIL rdwait_reserve_data: got %h @%h want %h @80002000", m1_readdata, addr, e.data); end
        clear_masters();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_tie();
        test_m0_read();
        test_m1_write_stall();
        test_rw_both();
        test_read_latency3();
        test_reset_rdwait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
